// File: rtl/riscv_core_dcache_writeback_unit.sv
// ============================================================================
// Module   : riscv_core_dcache_writeback_unit
// Brief    : Buffers dirty dcache victim lines and writes them out as AXI4
//            INCR bursts; exposes a lookup port for lines still pending.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_core_dcache_writeback_unit #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 256,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int WB_DEPTH       = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_evict_valid,
  output logic                        o_evict_ready,
  input  logic [ADDR_WIDTH-1:0]       i_evict_addr,
  input  logic [BLOCK_WIDTH-1:0]      i_evict_block,
  input  logic [ADDR_WIDTH-1:0]       i_lookup_addr,
  output logic                        o_lookup_hit,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [ADDR_WIDTH-1:0]       o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  output logic [BUS_DATA_WIDTH-1:0]   o_wdata,
  output logic [BUS_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wlast,
  input  logic                        i_bvalid,
  output logic                        o_bready,
  input  logic [1:0]                  i_bresp,
  output logic                        o_wb_busy,
  output logic                        o_wb_error
);

  localparam int c_BEATS  = BLOCK_WIDTH / BUS_DATA_WIDTH;
  localparam int c_BEAT_W = $clog2(c_BEATS);
  localparam int c_PTR_W  = $clog2(WB_DEPTH);
  localparam int c_OFF_W  = $clog2(BLOCK_WIDTH / 8);
  localparam int c_STRB_W = BUS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr  [WB_DEPTH];
  logic [BLOCK_WIDTH-1:0]    r_block [WB_DEPTH];
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_PTR_W:0]          r_count;
  logic [c_BEAT_W-1:0]       r_beat;
  logic [c_BEAT_W-1:0]       w_beat_nxt;
  logic                      r_wb_error;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_last;
  logic [BUS_DATA_WIDTH-1:0] w_words [c_BEATS];
  logic [WB_DEPTH-1:0]       w_entry_valid;
  logic [WB_DEPTH-1:0]       w_entry_match;
  logic                      w_unused;

  assign w_full        = (r_count == (c_PTR_W+1)'(WB_DEPTH));
  assign w_empty       = (r_count == '0);
  assign o_evict_ready = !w_full;
  assign w_push        = i_evict_valid && !w_full;
  assign w_pop         = (r_state == S_B) && i_bvalid;
  assign w_last        = (r_beat == c_BEAT_W'(c_BEATS - 1));

  // Line-offset bits and the low response bit carry no information here.
  assign w_unused = &{1'b0, i_evict_addr[c_OFF_W-1:0], i_lookup_addr[c_OFF_W-1:0], i_bresp[0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]  <= {i_evict_addr[ADDR_WIDTH-1:c_OFF_W], {c_OFF_W{1'b0}}};
      r_block[r_wr_ptr] <= i_evict_block;
    end
  end

  // An entry is live while its distance from the head is below the count;
  // the head stays live until its B response so the in-flight line still hits.
  for (genvar g = 0; g < WB_DEPTH; g++) begin : g_entry
    logic [c_PTR_W-1:0] w_rel;
    assign w_rel            = c_PTR_W'(g) - r_rd_ptr;
    assign w_entry_valid[g] = ({1'b0, w_rel} < r_count);
    assign w_entry_match[g] = w_entry_valid[g] &&
        (r_addr[g][ADDR_WIDTH-1:c_OFF_W] == i_lookup_addr[ADDR_WIDTH-1:c_OFF_W]);
  end

  assign o_lookup_hit = |w_entry_match;

  for (genvar k = 0; k < c_BEATS; k++) begin : g_word
    assign w_words[k] = r_block[r_rd_ptr][k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_wb_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_wb_error <= w_pop && i_bresp[1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    o_awvalid   = 1'b0;
    o_awaddr    = '0;
    o_wvalid    = 1'b0;
    o_wdata     = '0;
    o_wstrb     = '0;
    o_wlast     = 1'b0;
    o_bready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_AW;
      end
      S_AW: begin
        o_awvalid = 1'b1;
        o_awaddr  = r_addr[r_rd_ptr];
        if (i_awready) begin
          w_state_nxt = S_W;
          w_beat_nxt  = '0;
        end
      end
      S_W: begin
        o_wvalid = 1'b1;
        o_wdata  = w_words[r_beat];
        o_wstrb  = {c_STRB_W{1'b1}};
        o_wlast  = w_last;
        if (i_wready) begin
          w_beat_nxt = r_beat + c_BEAT_W'(1);
          if (w_last) w_state_nxt = S_B;
        end
      end
      S_B: begin
        o_bready = 1'b1;
        if (i_bvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_awlen    = 8'(c_BEATS - 1);
  assign o_awsize   = 3'($clog2(c_STRB_W));
  assign o_awburst  = 2'b01;
  assign o_wb_busy  = !w_empty || (r_state != S_IDLE);
  assign o_wb_error = r_wb_error;

endmodule

`default_nettype wire

// File: tb/tb_riscv_core_dcache_writeback_unit.sv
// ============================================================================
// Module   : tb_riscv_core_dcache_writeback_unit
// Brief    : Scoreboard bench for the dcache write-back unit with an AXI slave
//            model that can stall AW, toggle W ready, hold off B and inject errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_core_dcache_writeback_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         evict_valid = 1'b0;
  logic         evict_ready;
  logic [63:0]  evict_addr = '0;
  logic [255:0] evict_block = '0;
  logic [63:0]  lookup_addr = '0;
  logic         lookup_hit;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid;
  logic         wready = 1'b1;
  logic [63:0]  wdata;
  logic [7:0]   wstrb;
  logic         wlast;
  logic         bvalid = 1'b0;
  logic         bready;
  logic [1:0]   bresp = 2'b00;
  logic         wb_busy;
  logic         wb_error;

  riscv_core_dcache_writeback_unit dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_evict_valid (evict_valid),
    .o_evict_ready (evict_ready),
    .i_evict_addr  (evict_addr),
    .i_evict_block (evict_block),
    .i_lookup_addr (lookup_addr),
    .o_lookup_hit  (lookup_hit),
    .o_awvalid     (awvalid),
    .i_awready     (awready),
    .o_awaddr      (awaddr),
    .o_awlen       (awlen),
    .o_awsize      (awsize),
    .o_awburst     (awburst),
    .o_wvalid      (wvalid),
    .i_wready      (wready),
    .o_wdata       (wdata),
    .o_wstrb       (wstrb),
    .o_wlast       (wlast),
    .i_bvalid      (bvalid),
    .o_bready      (bready),
    .i_bresp       (bresp),
    .o_wb_busy     (wb_busy),
    .o_wb_error    (wb_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [63:0] exp_aw_q[$];
  logic [63:0] exp_w_q[$];

  // Slave model knobs
  int aw_stall_left = 0;
  bit w_toggle      = 1'b0;
  int b_hold_left   = 0;
  int err_left      = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      awready = 1'b0;
      bvalid  = 1'b0;
      wready  = 1'b1;
    end else begin
      if (awvalid && aw_stall_left > 0) begin
        awready = 1'b0;
        aw_stall_left--;
      end else begin
        awready = 1'b1;
      end
      wready = w_toggle ? ~wready : 1'b1;
      bvalid = bready && (b_hold_left == 0);
      if (b_hold_left > 0) b_hold_left--;
      bresp = (err_left > 0) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: protocol stability, scoreboard compare, error pulse tracking
  bit          prev_aw_stall, prev_w_stall, prev_b_hs, prev_b_err, prev_wlast;
  logic [63:0] prev_awaddr, prev_wdata;
  int          mon_beats  = 0;
  int          b_count    = 0;
  int          err_pulses = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_aw_stall = 0;
      prev_w_stall  = 0;
      prev_b_hs     = 0;
      prev_b_err    = 0;
      mon_beats     = 0;
    end else begin
      if (prev_aw_stall) begin
        check("aw_hold_valid", awvalid, 1);
        check("aw_hold_addr", awaddr, prev_awaddr);
      end
      if (prev_w_stall) begin
        check("w_hold_valid", wvalid, 1);
        check("w_hold_data", wdata, prev_wdata);
        check("w_hold_last", wlast, prev_wlast);
      end
      if (prev_b_hs || wb_error) check("wb_error", wb_error, prev_b_hs && prev_b_err);
      if (wb_error) err_pulses++;
      if (awvalid && awready) begin
        check("aw_expected", exp_aw_q.size() != 0, 1);
        if (exp_aw_q.size() != 0) check("awaddr", awaddr, exp_aw_q.pop_front());
        check("awlen", awlen, 3);
        check("awsize", awsize, 3);
        check("awburst", awburst, 1);
      end
      if (wvalid && wready) begin
        check("w_expected", exp_w_q.size() != 0, 1);
        if (exp_w_q.size() != 0) check("wdata", wdata, exp_w_q.pop_front());
        check("wstrb", wstrb, 8'hFF);
        check("wlast", wlast, mon_beats == 3);
        mon_beats++;
      end
      if (bvalid && bready) begin
        check("w_beats", mon_beats, 4);
        mon_beats = 0;
        b_count++;
        if (bresp[1] && err_left > 0) err_left--;
      end
      prev_b_hs     = bvalid && bready;
      prev_b_err    = bresp[1];
      prev_aw_stall = awvalid && !awready;
      prev_awaddr   = awaddr;
      prev_w_stall  = wvalid && !wready;
      prev_wdata    = wdata;
      prev_wlast    = wlast;
    end
  end

  function automatic logic [255:0] mk_block(input logic [15:0] seed);
    logic [255:0] b;
    for (int k = 0; k < 4; k++) b[k*64 +: 64] = {seed, 16'hC0DE, 24'h0, 8'(k)};
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic evict(input logic [63:0] addr, input logic [255:0] blk);
    bit ok = 0;
    evict_valid = 1'b1;
    evict_addr  = addr;
    evict_block = blk;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (evict_ready) begin ok = 1; break; end
    end
    check("evict_accept", ok, 1);
    if (ok) begin
      exp_aw_q.push_back({addr[63:5], 5'b0});
      for (int k = 0; k < 4; k++) exp_w_q.push_back(blk[k*64 +: 64]);
    end
    @(posedge clk);
    #1;
    evict_valid = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles);
    bit done = 0;
    busy_cycles = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (wb_busy) busy_cycles++;
      else if (exp_aw_q.size() == 0 && exp_w_q.size() == 0) begin done = 1; break; end
    end
    check("idle_reached", done, 1);
    @(posedge clk);
    #1;
  endtask

  int          cyc;
  logic [255:0] blk;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_wlast", wlast, 0);
    check("rst_busy", wb_busy, 0);
    check("rst_error", wb_error, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_evict_ready", evict_ready, 1);
    check("rst_lookup_hit", lookup_hit, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single evict with ready slave: 7 busy cycles
    evict(64'h8000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    wait_idle(cyc);
    check("single_busy_cycles", cyc, 7);
    check("single_busy_after", wb_busy, 0);

    // Back-pressure on AW and W
    aw_stall_left = 3;
    w_toggle      = 1'b1;
    evict(64'h0000_0000_1000_0040, mk_block(16'h0B0B));
    wait_idle(cyc);
    check("bp_aw_stall_used", aw_stall_left, 0);
    w_toggle = 1'b0;

    // Fill the FIFO with B held off; lookup against pending lines
    b_hold_left = 30;
    b_count     = 0;
    evict(64'h8000_1234, mk_block(16'hAAAA));
    evict(64'h9000_0008, mk_block(16'hBBBB));
    @(negedge clk);
    check("full_evict_ready", evict_ready, 0);
    lookup_addr = 64'h8000_123F; #1;
    check("lookup_inflight_hit", lookup_hit, 1);
    lookup_addr = 64'h8000_1240; #1;
    check("lookup_next_line_miss", lookup_hit, 0);
    lookup_addr = 64'h9000_001F; #1;
    check("lookup_second_hit", lookup_hit, 1);
    @(posedge clk); #1;
    evict(64'hA000_0040, mk_block(16'hCCCC));
    check("third_after_first_b", b_count >= 1, 1);
    wait_idle(cyc);
    lookup_addr = 64'h8000_123F; #1;
    check("lookup_after_b_miss", lookup_hit, 0);

    // SLVERR on the first of two bursts
    err_pulses = 0;
    err_left   = 1;
    evict(64'h0000_2000_0000_0000, mk_block(16'hD00D));
    evict(64'h0000_2000_0000_0020, mk_block(16'hE00E));
    wait_idle(cyc);
    check("error_pulses", err_pulses, 1);
    check("error_consumed", err_left, 0);

    // Reset during W beat 2
    blk = mk_block(16'hF00F);
    evict(64'h0000_3000_0000_0100, blk);
    begin
      bit seen = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk); #1;
        if (wvalid && wdata == blk[2*64 +: 64]) begin seen = 1; break; end
      end
      check("reached_beat2", seen, 1);
    end
    rst_n = 1'b0;
    #1;
    exp_aw_q.delete();
    exp_w_q.delete();
    check("midrst_awvalid", awvalid, 0);
    check("midrst_wvalid", wvalid, 0);
    check("midrst_bready", bready, 0);
    check("midrst_busy", wb_busy, 0);
    check("midrst_wdata", wdata, 0);
    lookup_addr = 64'h0000_3000_0000_0100; #1;
    check("midrst_lookup", lookup_hit, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_evict_ready", evict_ready, 1);
    check("post_rst_busy", wb_busy, 0);
    @(posedge clk); #1;
    evict(64'h0000_4000_0000_0000, mk_block(16'h1234));
    wait_idle(cyc);
    check("post_rst_busy_cycles", cyc, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
